// File: rtl/nn_mult_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM state codes and digit/partial-product widths.
package nn_mult_pkg;
  localparam int DIGIT_W = 2;
  localparam int PP_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult2_digit_sequencer_multiplier2.sv
// Gate-level 2x2 unsigned multiplier cell (Multiplier2): p = a * b using AND terms and a half-adder chain.
module Multiplier2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t10, t01, t11, c1;

  assign t10  = a[1] & b[0];
  assign t01  = a[0] & b[1];
  assign t11  = a[1] & b[1];
  assign c1   = t10 & t01;
  assign p[0] = a[0] & b[0];
  assign p[1] = t10 ^ t01;
  assign p[2] = t11 ^ c1;
  assign p[3] = t11 & c1;
endmodule

// File: rtl/mult2_digit_sequencer.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier: one 2x2 cell, one digit pair per RUN cycle.
// Optional MULT_ZERO_SKIP_EN: a zero operand jumps straight from IDLE to DONE with product 0.
module mult2_digit_sequencer
  import nn_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int P_W   = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(N - 2);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [P_W-1:0]     acc_reg, out_p_reg;
  logic               in_ready_reg, out_valid_reg, busy_reg;
  logic [IDX_W-1:0]   i_reg, j_reg;
  logic               last_pair_reg;

  logic [DIGIT_W-1:0] a_dig [N];
  logic [DIGIT_W-1:0] b_dig [N];
  logic [PP_W-1:0]    pp;
  logic [IDX_W:0]     digit_sum;
  logic [P_W-1:0]     pp_ext, term, acc_sum;
  logic               accept, run, zero_op;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digits
      assign a_dig[gi] = a_q[DIGIT_W*gi +: DIGIT_W];
      assign b_dig[gi] = b_q[DIGIT_W*gi +: DIGIT_W];
    end
  endgenerate

  Multiplier2 u_mul2 (
    .a (a_dig[i_reg]),
    .b (b_dig[j_reg]),
    .p (pp)
  );

  assign accept    = (state_reg == ST_IDLE) && in_valid && in_ready_reg;
  assign run       = (state_reg == ST_RUN);
  assign digit_sum = {1'b0, i_reg} + {1'b0, j_reg};
  assign pp_ext    = {{(P_W-PP_W){1'b0}}, pp};
  // Partial product weight is 4^(i+j); max shift keeps pp inside the 2*WIDTH accumulator.
  assign term      = pp_ext << (DIGIT_W * int'(digit_sum));
  assign acc_sum   = acc_reg + term;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Digit-pair counter: j is the inner index; last_pair_reg flags the pair (N-1,N-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg         <= '0;
      j_reg         <= '0;
      last_pair_reg <= 1'b0;
    end else if (accept) begin
      i_reg         <= '0;
      j_reg         <= '0;
      last_pair_reg <= 1'b0;
    end else if (run) begin
      if (j_reg == LAST_IDX) begin
        j_reg <= '0;
        i_reg <= i_reg + 1'b1;
      end else begin
        j_reg <= j_reg + 1'b1;
      end
      last_pair_reg <= (i_reg == LAST_IDX) && (j_reg == PEN_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      acc_reg       <= '0;
      out_p_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_q          <= in_a;
            b_q          <= in_b;
            acc_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (zero_op) begin
              state_reg     <= ST_DONE;
              out_valid_reg <= 1'b1;
              out_p_reg     <= '0;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_reg <= acc_sum;
          if (last_pair_reg) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            out_p_reg     <= acc_sum;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign busy      = busy_reg;
endmodule
